// File: rtl/asrv32_memoryaccess.sv
// ============================================================================
// Module   : asrv32_memoryaccess
// Brief    : ASRV32 load/store unit. It performs one req/ack data-memory
//            transaction per MEMORYACCESS stage and formats the load data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module asrv32_memoryaccess (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_ce,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2_data,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_load_data,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;

    logic        mem_op;
    logic        illegal;
    logic        start;
    logic [31:0] wdata_fmt;
    logic [3:0]  wstrb_fmt;

    function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] d);
        logic [31:0] s;
        s = d >> {off, 3'b000};
        case (f3)
            3'b000:  format_load = {{24{s[7]}}, s[7:0]};
            3'b001:  format_load = {{16{s[15]}}, s[15:0]};
            3'b100:  format_load = {24'd0, s[7:0]};
            3'b101:  format_load = {16'd0, s[15:0]};
            default: format_load = d;
        endcase
    endfunction

    // Reset also gates the decode so stall/fault cannot assert during reset.
    always_comb begin
        mem_op  = i_ce & i_rst_n & (i_is_load | i_is_store);
        illegal = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: illegal = 1'b0;
            3'b001, 3'b101: illegal = i_addr[0];
            3'b010:         illegal = |i_addr[1:0];
            default:        illegal = 1'b1;
        endcase
        if (i_is_store && i_funct3[2])
            illegal = 1'b1;
        if (i_is_load && i_is_store)
            illegal = 1'b1;
    end

    always_comb begin
        wdata_fmt = i_rs2_data;
        wstrb_fmt = 4'b1111;
        case (i_funct3[1:0])
            2'b00: begin
                wdata_fmt = {4{i_rs2_data[7:0]}};
                wstrb_fmt = 4'b0001 << i_addr[1:0];
            end
            2'b01: begin
                wdata_fmt = {2{i_rs2_data[15:0]}};
                wstrb_fmt = 4'b0011 << {i_addr[1], 1'b0};
            end
            default: begin
                wdata_fmt = i_rs2_data;
                wstrb_fmt = 4'b1111;
            end
        endcase
    end

    assign start     = (state == IDLE) & mem_op & ~illegal;
    assign o_fault   = (state == IDLE) & mem_op & illegal;
    assign o_stall   = start | (state == WAIT);
    assign o_mem_req = (state == WAIT);
    assign o_done    = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            funct3_q    <= 3'd0;
            offset_q    <= 2'd0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_wstrb <= 4'd0;
            o_load_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        funct3_q    <= i_funct3;
                        offset_q    <= i_addr[1:0];
                        o_mem_we    <= i_is_store;
                        o_mem_addr  <= {i_addr[31:2], 2'b00};
                        o_mem_wdata <= i_is_store ? wdata_fmt : 32'd0;
                        o_mem_wstrb <= i_is_store ? wstrb_fmt : 4'd0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_mem_ack) begin
                        if (!o_mem_we)
                            o_load_data <= format_load(funct3_q, offset_q, i_mem_rdata);
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_asrv32_memoryaccess.sv
// ============================================================================
// Module   : tb_asrv32_memoryaccess
// Brief    : Self-checking bench: directed and random loads/stores compared
//            against an arithmetic reference model of the load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_asrv32_memoryaccess;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, is_load, is_store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, rs2_data, mem_rdata;
    logic        mem_req, mem_we, stall, done, fault;
    logic [31:0] mem_addr, mem_wdata, load_data;
    logic [3:0]  mem_wstrb;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ld   = 32'd0;

    always #5 clk = ~clk;

    asrv32_memoryaccess dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ce(ce),
        .i_is_load(is_load), .i_is_store(is_store), .i_funct3(funct3),
        .i_addr(addr), .i_rs2_data(rs2_data),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_load_data(load_data), .o_stall(stall), .o_done(done), .o_fault(fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- reference model, from the access rules ----
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_fault(input bit ld, input bit st, input logic [2:0] f3,
                                       input logic [31:0] a);
        bit legal;
        if (ld && st) return 1'b1;
        legal = ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 inside {3'd0, 3'd1, 3'd2});
        if (!legal) return 1'b1;
        return (a % nbytes(f3)) != 0;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        r = 32'd0;
        for (int b = 0; b < 4; b++)
            r = r | (((d >> (8 * (b % n))) & 32'hFF) << (8 * b));
        return r;
    endfunction

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int m;
        m = ((1 << nbytes(f3)) - 1) << (a % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        longint v;
        int n;
        n = nbytes(f3);
        if (n == 4) return d;
        v = (longint'(d) >> (8 * (a % 4))) % (longint'(1) << (8 * n));
        if (!f3[2] && v >= (longint'(1) << (8 * n - 1)))
            v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One MEMORYACCESS stage; the ack arrives in the nreq-th request cycle.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] rd, input int nreq);
        int stall_cnt;
        logic [31:0] exp_addr, exp_wd;
        logic [3:0]  exp_ws;
        ce = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; rs2_data = d;
        mem_ack = 1'b0;
        #1;
        if (!(ld || st)) begin
            check("nonmem_stall", stall, 0);
            check("nonmem_fault", fault, 0);
            tick();
            check("nonmem_req", mem_req, 0);
            check("nonmem_done", done, 0);
            ce = 1'b0;
            return;
        end
        if (model_fault(ld, st, f3, a)) begin
            check("fault_pulse", fault, 1);
            check("fault_stall", stall, 0);
            tick();
            check("fault_req", mem_req, 0);
            check("fault_done", done, 0);
            ce = 1'b0;
            #1;
            check("fault_end", fault, 0);
            return;
        end
        check("start_stall", stall, 1);
        check("start_fault", fault, 0);
        stall_cnt = 1;
        exp_addr = a & 32'hFFFF_FFFC;
        exp_wd   = st ? model_wdata(f3, d) : 32'd0;
        exp_ws   = st ? model_wstrb(f3, a) : 4'd0;
        tick();
        for (int k = 1; k <= nreq; k++) begin
            mem_ack   = (k == nreq);
            mem_rdata = (k == nreq) ? rd : $urandom;
            addr      = $urandom;
            rs2_data  = $urandom;
            #1;
            check("wait_req", mem_req, 1);
            check("wait_addr", mem_addr, exp_addr);
            check("wait_we", mem_we, st);
            check("wait_wdata", mem_wdata, exp_wd);
            check("wait_wstrb", mem_wstrb, exp_ws);
            if (stall) stall_cnt++;
            tick();
        end
        mem_ack = 1'b0;
        ce = 1'b0;
        #1;
        if (ld) exp_ld = model_load(f3, a, rd);
        check("done_pulse", done, 1);
        check("done_stall", stall, 0);
        check("done_req", mem_req, 0);
        check("stall_cycles", stall_cnt, nreq + 1);
        check("load_data", load_data, exp_ld);
        tick();
        check("done_end", done, 0);
        check("idle_req", mem_req, 0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
        addr = 32'd0; rs2_data = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
        #12;
        check("rst_req", mem_req, 0);
        check("rst_stall", stall, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("rst_ld", load_data, 0);
        rst_n = 1'b1;
        tick();

        do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
        do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 3);
        do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 3);
        do_op(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
        do_op(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
        do_op(0, 1, 3'b001, 32'h003, 32'h0, 32'h0, 1);
        do_op(0, 0, 3'b000, 32'h40, 32'h0, 32'h0, 1);

        // Ack while no request is outstanding must be ignored.
        mem_ack = 1'b1;
        tick();
        check("stray_ack_done", done, 0);
        mem_ack = 1'b0;

        // Reset during WAIT with ack withheld.
        ce = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h300;
        tick();
        tick();
        check("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        exp_ld = 32'd0;
        check("abort_req", mem_req, 0);
        check("abort_stall", stall, 0);
        check("abort_ld", load_data, 0);
        ce = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        do_op(1, 0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 2);

        for (int i = 0; i < 150; i++) begin
            bit ld, st;
            int sel;
            sel = $urandom_range(0, 9);
            ld = (sel < 5) || (sel == 9);
            st = (sel >= 5 && sel < 8) || (sel == 9);
            do_op(ld, st, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                  $urandom_range(1, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
